// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array output-buffer drain path.
// Holds the row/beat/address geometry and the drain FSM state encoding used by
// output_buffer_drain and drain_row_serializer.
package systolic_pkg;

  localparam int DATA_W     = 1024;
  localparam int BEAT_W     = 64;
  localparam int ADDR_W     = 13;
  localparam int CNT_W      = 6;
  localparam int BEATS      = DATA_W / BEAT_W;
  localparam int BEAT_IDX_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } drain_state_e;

endpackage

// File: rtl/drain_row_serializer.sv
// drain_row_serializer: holds one DATA_W row and emits it as BEATS beats of
// BEAT_W bits on a valid/ready stream, beat 0 = row bits [BEAT_W-1:0].
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   load_i, row_i  load a new row (restarts at beat 0, may coincide with the
//                  final handshake of the previous row for back-to-back rows)
//   valid_o, ready_i, data_o  beat stream; data_o is zero while not valid
//   last_beat_o    the beat currently offered is the final beat of the row
//   row_done_o     handshake of the final beat happens this cycle
module drain_row_serializer
  import systolic_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] row_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [BEAT_W-1:0] data_o,
  output logic              last_beat_o,
  output logic              row_done_o
);

  logic [DATA_W-1:0]     row_q, row_d;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  logic                  active_q, active_d;
  logic                  handshake;

  assign handshake   = active_q & ready_i;
  assign last_beat_o = active_q & (beat_q == BEAT_IDX_W'(BEATS - 1));
  assign row_done_o  = handshake & last_beat_o;
  assign valid_o     = active_q;
  assign data_o      = active_q ? row_q[BEAT_W*beat_q +: BEAT_W] : '0;

  // A load takes priority over the handshake so the next row can follow the
  // last beat of the current one without a bubble.
  always_comb begin
    row_d    = row_q;
    beat_d   = beat_q;
    active_d = active_q;
    if (load_i) begin
      row_d    = row_i;
      beat_d   = '0;
      active_d = 1'b1;
    end else if (handshake) begin
      if (last_beat_o) begin
        beat_d   = '0;
        active_d = 1'b0;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q    <= '0;
      beat_q   <= '0;
      active_q <= 1'b0;
    end else begin
      row_q    <= row_d;
      beat_q   <= beat_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/output_buffer_drain.sv
// output_buffer_drain: reads a run of consecutive rows from the output buffer
// (registered read, Q zero on non-read cycles) and streams each row as 64-bit
// beats toward the writeback path.
// Ports:
//   CLK, RETN            clock, asynchronous active-low reset
//   start, base_addr, num_rows  command, sampled only while idle
//   busy, done           busy from accepted start to done; done is a 1-cycle pulse
//   buf_cen, buf_wen, buf_a, buf_q  buffer read port (buf_wen tied high)
//   m_valid, m_ready, m_data, m_last  beat stream; m_last on the final beat
// Configuration:
//   DRAIN_PREFETCH_EN  when defined, the next row is read into a second
//                      register during SEND so rows stream without bubbles.
module output_buffer_drain
  import systolic_pkg::*;
(
  input  logic              CLK,
  input  logic              RETN,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_rows,
  output logic              busy,
  output logic              done,
  output logic              buf_cen,
  output logic              buf_wen,
  output logic [ADDR_W-1:0] buf_a,
  input  logic [DATA_W-1:0] buf_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BEAT_W-1:0] m_data,
  output logic              m_last
);

  drain_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]  snd_idx_q, snd_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;

  logic              read_now;
  logic [ADDR_W-1:0] rd_addr;
  logic              last_row;
  logic              ser_load;
  logic [DATA_W-1:0] ser_row;
  logic              ser_valid;
  logic              ser_last_beat;
  logic              ser_row_done;

`ifdef DRAIN_PREFETCH_EN
  logic [DATA_W-1:0] next_q, next_d;
  logic              next_valid_q, next_valid_d;
  logic              pf_cap_q, pf_cap_d;
`endif

  // rd_idx counts rows already read; snd_idx is the row now in the serializer.
  // They differ only when prefetching runs one row ahead.
  assign rd_addr  = base_q + ADDR_W'(rd_idx_q);
  assign last_row = (snd_idx_q == num_q - CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    rd_idx_d  = rd_idx_q;
    snd_idx_d = snd_idx_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    read_now  = 1'b0;
    ser_load  = 1'b0;
    ser_row   = buf_q;
`ifdef DRAIN_PREFETCH_EN
    next_d       = next_q;
    next_valid_d = next_valid_q;
    pf_cap_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_addr;
          num_d     = num_rows;
          rd_idx_d  = '0;
          snd_idx_d = '0;
          // An empty run completes immediately without ever raising busy.
          if (num_rows == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        read_now = 1'b1;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        // buf_q carries the row only in this cycle; elsewhere it reads zero.
        ser_load = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (ser_row_done) begin
          if (last_row) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            snd_idx_d = snd_idx_q + CNT_W'(1);
`ifdef DRAIN_PREFETCH_EN
            // A row takes at least BEATS cycles, far longer than the two-cycle
            // read/capture, so next_reg is always filled by this point.
            ser_load     = 1'b1;
            ser_row      = next_q;
            next_valid_d = 1'b0;
`else
            state_d = READ;
`endif
          end
        end
`ifdef DRAIN_PREFETCH_EN
        if ((rd_idx_q < num_q) && !next_valid_q && !pf_cap_q) begin
          read_now = 1'b1;
          pf_cap_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (read_now) begin
      addr_d   = rd_addr;
      rd_idx_d = rd_idx_q + CNT_W'(1);
    end

`ifdef DRAIN_PREFETCH_EN
    if (pf_cap_q) begin
      next_d       = buf_q;
      next_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RETN) begin
    if (!RETN) begin
      state_q   <= IDLE;
      base_q    <= '0;
      num_q     <= '0;
      rd_idx_q  <= '0;
      snd_idx_q <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      rd_idx_q  <= rd_idx_d;
      snd_idx_q <= snd_idx_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
    end
  end

`ifdef DRAIN_PREFETCH_EN
  always_ff @(posedge CLK or negedge RETN) begin
    if (!RETN) begin
      next_q       <= '0;
      next_valid_q <= 1'b0;
      pf_cap_q     <= 1'b0;
    end else begin
      next_q       <= next_d;
      next_valid_q <= next_valid_d;
      pf_cap_q     <= pf_cap_d;
    end
  end
`endif

  drain_row_serializer u_serializer (
    .clk_i       (CLK),
    .rst_ni      (RETN),
    .load_i      (ser_load),
    .row_i       (ser_row),
    .valid_o     (ser_valid),
    .ready_i     (m_ready),
    .data_o      (m_data),
    .last_beat_o (ser_last_beat),
    .row_done_o  (ser_row_done)
  );

  // buf_a shows the live address during a read and holds it otherwise.
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign buf_cen = ~read_now;
  assign buf_wen = 1'b1;
  assign buf_a   = read_now ? rd_addr : addr_q;
  assign m_valid = ser_valid;
  assign m_last  = ser_last_beat & last_row;

endmodule

// File: tb/tb_output_buffer_drain.sv
// Testbench for output_buffer_drain: a 32-row buffer model feeds the DUT, a
// negedge monitor records reads, beats and done pulses, and each transfer is
// compared against beats and cycle numbers computed from the row contents.
module tb_output_buffer_drain;
  import systolic_pkg::*;

  logic              CLK;
  logic              RETN;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_rows;
  logic              busy;
  logic              done;
  logic              buf_cen;
  logic              buf_wen;
  logic [ADDR_W-1:0] buf_a;
  logic [DATA_W-1:0] bufQ;
  logic              m_valid;
  logic              m_ready;
  logic [BEAT_W-1:0] m_data;
  logic              m_last;

  int checks;
  int errors;
  int cyc;
  int readyMode;

  logic [DATA_W-1:0] mem [32];

  logic [BEAT_W-1:0] beatQ[$];
  logic              beatLastQ[$];
  int                beatCycQ[$];
  int                readAddrQ[$];
  int                readCycQ[$];
  int                doneCount;
  int                doneCyc;
  bit                busySeen;

  typedef struct {
    int base;
    int nrows;
    int mode;
    int spurAt;
    int expBeats;
    int expReads;
  } vec_t;

  vec_t vecs[8];

  output_buffer_drain dut (
    .CLK       (CLK),
    .RETN      (RETN),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .buf_cen   (buf_cen),
    .buf_wen   (buf_wen),
    .buf_a     (buf_a),
    .buf_q     (bufQ),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Buffer model: registered read, zeros whenever the previous cycle did not read.
  always @(posedge CLK) bufQ <= (!buf_cen) ? mem[buf_a[4:0]] : '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},    busy,    0);
    checkOutput({tag, "_done"},    done,    0);
    checkOutput({tag, "_valid"},   m_valid, 0);
    checkOutput({tag, "_last"},    m_last,  0);
    checkOutput({tag, "_cen"},     buf_cen, 1);
    checkOutput({tag, "_wen"},     buf_wen, 1);
    checkOutput({tag, "_addr"},    buf_a,   0);
    checkOutput({tag, "_data"},    m_data,  0);
  endtask

  task automatic clearMonitor();
    beatQ.delete();
    beatLastQ.delete();
    beatCycQ.delete();
    readAddrQ.delete();
    readCycQ.delete();
    doneCount = 0;
    doneCyc   = -1;
    busySeen  = 0;
  endtask

  function automatic logic [63:0] modelBeat(input int base, input int idx);
    int row;
    logic [DATA_W-1:0] r;
    row = (base + idx / BEATS) % 8192;
    r   = mem[row % 32];
    return r[BEAT_W*(idx % BEATS) +: BEAT_W];
  endfunction

  // Cycle numbers relative to the start cycle, with m_ready held high.
  function automatic int modelReadCycle(input int r);
`ifdef DRAIN_PREFETCH_EN
    return (r == 0) ? 1 : 3 + 16 * (r - 1);
`else
    return 1 + 18 * r;
`endif
  endfunction

  function automatic int modelBeatCycle(input int i);
`ifdef DRAIN_PREFETCH_EN
    return 3 + i;
`else
    return 3 + 18 * (i / BEATS) + (i % BEATS);
`endif
  endfunction

  function automatic int modelDoneCycle(input int n);
    if (n == 0) return 1;
`ifdef DRAIN_PREFETCH_EN
    return 3 + 16 * n;
`else
    return 1 + 18 * n;
`endif
  endfunction

  task automatic randomizeRow(input int r);
    for (int w = 0; w < DATA_W / 32; w++) mem[r][32*w +: 32] = $urandom();
  endtask

  // Ready pattern generator: 0 = always ready, 1 = 1,0,0,1 repeating, else random.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (readyMode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: records reads, handshakes and done pulses, and checks that a
  // stalled beat is held unchanged into the next cycle.
  initial begin
    logic              prevStall;
    logic [BEAT_W-1:0] prevData;
    logic              prevLast;
    prevStall = 0;
    prevData  = '0;
    prevLast  = 0;
    forever begin
      @(negedge CLK);
      if (RETN) begin
        if (prevStall) begin
          checkOutput("stall_valid", m_valid, 1);
          checkOutput("stall_data",  m_data,  prevData);
          checkOutput("stall_last",  m_last,  prevLast);
        end
        if (!buf_cen) begin
          readAddrQ.push_back(int'(buf_a));
          readCycQ.push_back(cyc);
        end
        if (m_valid && m_ready) begin
          beatQ.push_back(m_data);
          beatLastQ.push_back(m_last);
          beatCycQ.push_back(cyc);
        end
        if (done) begin
          doneCount++;
          doneCyc = cyc;
        end
        if (busy) busySeen = 1;
        prevStall = m_valid && !m_ready;
        prevData  = m_data;
        prevLast  = m_last;
      end else begin
        prevStall = 0;
      end
    end
  end

  task automatic applyStimulus(input int base, input int n, input int mode, input int spurAt,
                               input int expBeats, input int expReads);
    int t0;
    int budget;
    @(posedge CLK);
    #1;
    clearMonitor();
    readyMode = mode;
    base_addr = ADDR_W'(base);
    num_rows  = CNT_W'(n);
    start     = 1'b1;
    t0        = cyc;
    budget    = 120 * n + 40;
    for (int i = 1; i <= budget && doneCount == 0; i++) begin
      @(posedge CLK);
      #1;
      start = (i == spurAt);
      if (start) begin
        base_addr = ADDR_W'(base + 7);
        num_rows  = CNT_W'(n + 3);
      end
    end
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("done_count", doneCount, 1);
    if (mode == 0) checkOutput("done_cycle", doneCyc - t0, modelDoneCycle(n));
    checkOutput("busy_seen",  busySeen, (n > 0));
    checkOutput("busy_after", busy, 0);
    checkOutput("beat_count", beatQ.size(), expBeats);
    checkOutput("read_count", readAddrQ.size(), expReads);
    for (int i = 0; i < beatQ.size() && i < expBeats; i++) begin
      checkOutput("beat_data", beatQ[i], modelBeat(base, i));
      checkOutput("beat_last", beatLastQ[i], (i == expBeats - 1));
      if (mode == 0) checkOutput("beat_cycle", beatCycQ[i] - t0, modelBeatCycle(i));
    end
    for (int r = 0; r < readAddrQ.size() && r < expReads; r++) begin
      checkOutput("read_addr", readAddrQ[r], (base + r) % 8192);
      if (mode == 0) checkOutput("read_cycle", readCycQ[r] - t0, modelReadCycle(r));
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    readyMode = 0;
    RETN      = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    clearMonitor();

    for (int r = 0; r < 32; r++) randomizeRow(r);
    for (int k = 0; k < BEATS; k++) mem[5][BEAT_W*k +: BEAT_W] = 64'(k * 257);

    vecs[0] = '{5,    1, 0, 0,  16, 1};
    vecs[1] = '{30,   2, 0, 0,  32, 2};
    vecs[2] = '{5,    1, 1, 0,  16, 1};
    vecs[3] = '{9,    0, 0, 0,  0,  0};
    vecs[4] = '{5,    2, 0, 10, 32, 2};
    vecs[5] = '{8190, 3, 0, 0,  48, 3};
    vecs[6] = '{12,   4, 0, 0,  64, 4};
    vecs[7] = '{3,    2, 2, 0,  32, 2};

    repeat (3) @(posedge CLK);
    #3;
    checkResetOutputs("reset");
    RETN = 1'b1;
    repeat (2) @(posedge CLK);

    for (int v = 0; v < 8; v++) begin
      $display("[TB] vector %0d base=%0d rows=%0d mode=%0d", v, vecs[v].base, vecs[v].nrows, vecs[v].mode);
      applyStimulus(vecs[v].base, vecs[v].nrows, vecs[v].mode, vecs[v].spurAt,
                    vecs[v].expBeats, vecs[v].expReads);
      if (v == 0) checkOutput("row5_beat15", beatQ[15], 64'h0F0F);
    end

    // Reset while beat 7 of row 0 is on the bus: everything drops at once, no done.
    @(posedge CLK);
    #1;
    clearMonitor();
    readyMode = 0;
    base_addr = ADDR_W'(5);
    num_rows  = CNT_W'(2);
    start     = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100 && beatQ.size() < 7; i++) begin
      @(posedge CLK);
      #1;
    end
    checkOutput("reach_beat7", beatQ.size(), 7);
    #1;
    RETN = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    repeat (3) @(posedge CLK);
    #2;
    RETN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("no_done_after_reset", doneCount, 0);
    checkOutput("idle_after_reset", busy, 0);

    for (int t = 0; t < 6; t++) begin
      int b;
      int n;
      b = int'($urandom_range(0, 8191));
      n = int'($urandom_range(1, 5));
      for (int r = 0; r < n; r++) randomizeRow((b + r) % 32);
      applyStimulus(b, n, int'($urandom_range(1, 2)), 0, BEATS * n, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/output_buffer_drain.md
Name: output_buffer_drain

Overview:
- Read-side engine for the systolic-array output buffer (1024-bit rows, 32 deep, registered read, Q forced to zero on non-read cycles).
- On a start command it reads a run of consecutive rows through the buffer's CEN/WEN/A/Q port.
- It captures each row in the cycle its Q is valid and serializes it into 64-bit beats on a valid/ready stream toward the writeback path.
- It sits between output_buffer and the DRAM/host writeback interface.

Parameters:
- DATA_W, 1024, buffer row width.
- BEAT_W, 64, stream beat width; DATA_W must be a multiple of BEAT_W; BEATS = DATA_W/BEAT_W = 16.
- ADDR_W, 13, buffer address width.
- CNT_W, 6, row-count width (1..32 rows).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RETN  in  1  asynchronous active-low reset.
- start  in  1  command strobe, sampled only in IDLE.
- base_addr  in  ADDR_W  first row address, latched with start.
- num_rows  in  CNT_W  rows to drain, latched with start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the final beat handshake.
- buf_cen  out  1  active-low read enable to buffer.
- buf_wen  out  1  buffer write enable; constant 1, never writes.
- buf_a  out  ADDR_W  buffer address.
- buf_q  in  DATA_W  buffer read data; valid the cycle after buf_cen=0.
- m_valid  out  1  beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  BEAT_W  beat payload.
- m_last  out  1  marks the last beat of the last row.

Behaviour:
- **Reset** (RETN=0, asynchronous): state IDLE; busy, done, m_valid and m_last are 0; buf_cen=1; buf_a=0; m_data=0; counters and row registers cleared.
  - Reset mid-transfer abandons the transfer with no done pulse.
  - Reset release needs no start re-arm.
- **States:** IDLE, READ, CAPTURE, SEND.
  - IDLE: on start=1 latch base_addr and num_rows, set busy, go to READ. If num_rows=0, skip READ, pulse done next cycle and stay IDLE; busy is not raised.
  - READ: exactly one cycle with buf_cen=0 and buf_a = base + row_idx (mod 2^ADDR_W) → CAPTURE.
  - CAPTURE: row_reg <= buf_q at the end of this cycle → SEND, beat_idx=0.
  - SEND: m_valid=1, m_data = row_reg[BEAT_W*beat_idx +: BEAT_W]; beat 0 is bits [63:0].
    - Handshake is m_valid & m_ready. Each handshake increments beat_idx.
    - On the handshake of beat BEATS-1: if more rows remain, row_idx++ and go to READ; otherwise go to IDLE, clear busy, pulse done.
- **Stream rules:**
  - m_data, m_valid and m_last stay stable while m_valid & !m_ready.
  - m_valid is never dropped without a handshake.
  - m_last=1 only on beat 15 of row num_rows-1.
- **Buffer port rules:**
  - buf_cen=0 only in READ.
  - buf_a holds its last value when buf_cen=1.
  - buf_q is ignored outside the capture cycle, because the buffer outputs zeros then.
- **Other boundaries:**
  - start while busy is ignored.
  - Address wrap past 2^ADDR_W-1 is modulo.
  - Rows beyond physical depth are the caller's responsibility.
- **Latency** (start accepted in cycle 0, m_ready held 1):
  - Read in cycle 1, first beat in cycle 3.
  - Each row costs 18 cycles; the last beat lands in cycle 18·N; done pulses in cycle 18·N+1.

Optional Feature:
- Macro: DRAIN_PREFETCH_EN.
- Defined:
  - Adds a second DATA_W register, next_reg, with a valid flag.
  - While in SEND, if rows remain, next_reg is empty and no read is in flight, the block issues the next row's READ/CAPTURE concurrently.
  - On the handshake of beat 15, next_reg moves into row_reg and SEND continues at beat 0 with no bubble.
  - Latency with m_ready=1: last beat in cycle 2+16·N, done in cycle 3+16·N.
  - Buffer reads occur one row ahead; never more than one read is outstanding.
- Undefined: the sequential behaviour described above, with 2 idle cycles between rows.

Decomposition:
- Shared package (systolic_pkg):
  - DATA_W, BEAT_W, ADDR_W constants.
  - BEATS localparam.
  - drain state enum (IDLE/READ/CAPTURE/SEND).
- One natural sub-module, drain_row_serializer:
  - Loads a DATA_W row on load, emits BEATS beats with valid/ready, raises row_done on the last handshake.
  - Instantiated once; the top module keeps the FSM, address/row counters and prefetch register.

Test Plan:
- Row 5 preloaded with beat k = 64'h0000_0000_0000_0000+k·0x0101; start base=5, num_rows=1, m_ready=1 → buf_cen low in cycle 1 with buf_a=5; 16 beats in cycles 3–18 with values 0x0000…0x0F0F; m_last on beat 15; done in cycle 19.
- base=30, num_rows=2, rows 30/31 distinct patterns → buf_a=30 then 31; 32 beats in order; m_last only on the 32nd; done once.
- m_ready toggled 1,0,0,1 repeatedly during row 0 → m_data stable across stalls; no beat lost or duplicated; beat count 16.
- num_rows=0 → no buf_cen assertion; busy stays 0; done pulses the cycle after start.
- start pulsed again mid-transfer → ignored, transfer completes unchanged. Then RETN low at beat 7 → all outputs at reset values immediately; no done.
- With DRAIN_PREFETCH_EN, num_rows=4, m_ready=1 → 64 contiguous valid beats in cycles 3–66; done in cycle 67; at most one buf_cen=0 per 16 cycles after the first.
